// File: rtl/plic_gateway.sv
// plic_gateway: per-source level/edge interrupt gateway feeding the plic, one outstanding request per source.
// Optional GATEWAY_SYNC_EN inserts a 2-flop synchronizer on each irq_in bit.
module plic_gateway #(
  parameter int PORTS = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] irq_in,
  input  logic [PORTS-1:0] edge_mode,
  input  logic [PORTS-1:0] int_claim,
  input  logic [PORTS-1:0] int_complete,
  output logic [PORTS-1:0] int_signal,
  output logic [PORTS-1:0] int_active,
  output logic [PORTS-1:0] edge_ovf,
  input  logic [PORTS-1:0] ovf_clear
);
  localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, ACT = 2'd2;
  logic [PORTS-1:0] w_irq, r_irq_q, w_rise, w_ovf_set, r_ovf;
`ifdef GATEWAY_SYNC_EN
  logic [PORTS-1:0] r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    r_sync1 <= rst ? '0 : irq_in;
    r_sync2 <= rst ? '0 : r_sync1;
  end
  assign w_irq = r_sync2;
`else
  assign w_irq = irq_in;
`endif
  // irq_q clears on reset so a line already high at release reads as a rise
  always_ff @(posedge clk) begin
    r_irq_q <= rst ? '0 : w_irq;
    r_ovf   <= rst ? '0 : (w_ovf_set | (r_ovf & ~ovf_clear));
  end
  assign w_rise   = w_irq & ~r_irq_q;
  assign edge_ovf = r_ovf;
  genvar i;
  generate
    for (i = 0; i < PORTS; i++) begin : g_src
      logic [1:0]       r_state, w_next;
      logic [CNT_W-1:0] r_cnt, w_cnt;
      logic             w_done, w_inc, w_sat, w_sig, w_act;
      assign w_done = (r_state == ACT) && int_complete[i];
      assign w_inc  = edge_mode[i] && w_rise[i] && (r_state == PEND || r_state == ACT);
      assign w_sat  = &r_cnt;
      always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
        r_cnt   <= rst ? '0 : w_cnt;
      end
      always_comb begin
        w_next = (r_state == IDLE) ? ((edge_mode[i] ? w_rise[i] : w_irq[i]) ? PEND : IDLE)
               : (r_state == PEND) ? (int_claim[i] ? ACT : PEND)
               : (r_state == ACT)  ? (!int_complete[i] ? ACT
                                      : (edge_mode[i] && (w_rise[i] || r_cnt != '0)) ? PEND : IDLE)
               : IDLE;
        // a rise coinciding with complete is consumed by the re-pend, so the count is untouched
        w_cnt  = w_done ? ((edge_mode[i] && !w_rise[i] && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt)
               : ((w_inc && !w_sat) ? r_cnt + 1'b1 : r_cnt);
      end
      always_comb begin
        w_sig = (r_state == PEND);
        w_act = (r_state == ACT);
      end
      assign int_signal[i] = w_sig;
      assign int_active[i] = w_act;
      assign w_ovf_set[i]  = w_inc && !w_done && w_sat;
    end
  endgenerate
endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed vector table, hand sequences and a random run against a queue-count model.
module tb_plic_gateway;
  localparam int P = 4;
  localparam int QMAX = 7;
  logic clk = 1'b0, rst = 1'b1;
  logic [P-1:0] irq_in = '0, edge_mode = '0, int_claim = '0, int_complete = '0, ovf_clear = '0;
  logic [P-1:0] int_signal, int_active, edge_ovf;
  int total = 0, bad = 0;
  plic_gateway #(.PORTS(P), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode),
    .int_claim(int_claim), .int_complete(int_complete),
    .int_signal(int_signal), .int_active(int_active),
    .edge_ovf(edge_ovf), .ovf_clear(ovf_clear)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [P-1:0] irq, mode, clm, cmp, clr, sig, act, ovf;
  } vec_t;
  vec_t tv[$];
  // model: 0 = nothing requested, 1 = waiting for claim, 2 = being serviced
  int m_st[P], m_q[P];
  bit m_ovf[P], m_prev[P];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [P-1:0] got, input logic [P-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask
  task automatic add(input logic [P-1:0] irq, mode, clm, cmp, clr, sig, act, ovf);
    vec_t v;
    v.irq = irq; v.mode = mode; v.clm = clm; v.cmp = cmp; v.clr = clr;
    v.sig = sig; v.act = act; v.ovf = ovf;
    tv.push_back(v);
  endtask
  task automatic model_step();
    for (int s = 0; s < P; s++) begin
      bit r, e, set;
      r = irq_in[s] && !m_prev[s];
      e = edge_mode[s];
      set = 0;
      if (rst) begin
        m_st[s] = 0; m_q[s] = 0; m_ovf[s] = 0; m_prev[s] = 0;
        continue;
      end
      if (m_st[s] == 0) begin
        if (e ? r : irq_in[s]) m_st[s] = 1;
      end else if (m_st[s] == 2 && int_complete[s]) begin
        if (e && r) m_st[s] = 1;
        else if (e && m_q[s] > 0) begin m_q[s]--; m_st[s] = 1; end
        else m_st[s] = 0;
      end else begin
        if (e && r) begin
          if (m_q[s] == QMAX) set = 1; else m_q[s]++;
        end
        if (m_st[s] == 1 && int_claim[s]) m_st[s] = 2;
      end
      m_ovf[s] = set ? 1'b1 : (ovf_clear[s] ? 1'b0 : m_ovf[s]);
      m_prev[s] = irq_in[s];
    end
  endtask
  function automatic logic [P-1:0] m_vec(input int kind);
    logic [P-1:0] v;
    for (int s = 0; s < P; s++)
      v[s] = (kind == 0) ? (m_st[s] == 1) : (kind == 1) ? (m_st[s] == 2) : m_ovf[s];
    return v;
  endfunction
  initial begin
    tick(); tick();
    chk("rst_sig", int_signal, 4'b0000);
    chk("rst_act", int_active, 4'b0000);
    chk("rst_ovf", edge_ovf, 4'b0000);
    rst = 1'b0;
    //   irq      mode     claim    compl    clr      sig      act      ovf
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
      add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    end
    for (int k = 0; k < 3; k++) begin
      add(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      add(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    end
    add(4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    add(4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add(4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add(4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    add(4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add(4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    foreach (tv[k]) begin
      irq_in = tv[k].irq; edge_mode = tv[k].mode; int_claim = tv[k].clm;
      int_complete = tv[k].cmp; ovf_clear = tv[k].clr;
      tick();
      chk($sformatf("v%0d_sig", k), int_signal, tv[k].sig);
      chk($sformatf("v%0d_act", k), int_active, tv[k].act);
      chk($sformatf("v%0d_ovf", k), edge_ovf, tv[k].ovf);
    end
    irq_in = '0; int_claim = '0; int_complete = '0; ovf_clear = '0; edge_mode = 4'b0100;
    tick();
    irq_in = 4'b0100; tick(); chk("sat_pend", int_signal, 4'b0100);
    irq_in = '0; int_claim = 4'b0100; tick(); int_claim = '0; chk("sat_act", int_active, 4'b0100);
    for (int p = 1; p <= 9; p++) begin
      irq_in = 4'b0100; tick(); irq_in = '0; tick();
      chk($sformatf("sat_ovf%0d", p), edge_ovf, (p >= 8) ? 4'b0100 : 4'b0000);
    end
    ovf_clear = 4'b0100; tick(); ovf_clear = '0; chk("ovf_clr", edge_ovf, 4'b0000);
    irq_in = 4'b0100; ovf_clear = 4'b0100; tick();
    irq_in = '0; ovf_clear = '0; chk("ovf_set_wins", edge_ovf, 4'b0100);
    for (int r = 0; r < 8; r++) begin
      int_complete = 4'b0100; tick(); int_complete = '0;
      chk($sformatf("drain%0d", r), int_signal, (r < 7) ? 4'b0100 : 4'b0000);
      if (r < 7) begin int_claim = 4'b0100; tick(); int_claim = '0; end
    end
    ovf_clear = 4'b0100; tick(); ovf_clear = '0;
    edge_mode = 4'b0010; irq_in = 4'b0011; tick(); chk("pre_rst_sig", int_signal, 4'b0011);
    int_claim = 4'b0010; tick(); int_claim = '0; chk("pre_rst_act", int_active, 4'b0010);
    for (int k = 0; k < 2; k++) begin
      irq_in = 4'b0001; tick(); irq_in = 4'b0011; tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_sig", int_signal, 4'b0000);
    chk("mid_rst_act", int_active, 4'b0000);
    chk("mid_rst_ovf", edge_ovf, 4'b0000);
    tick(); chk("post_rst_sig", int_signal, 4'b0011);
    int_claim = 4'b0011; tick(); int_claim = '0; chk("post_rst_act", int_active, 4'b0011);
    int_complete = 4'b0011; tick(); int_complete = '0;
    chk("post_cmp_sig", int_signal, 4'b0000);
    chk("post_cmp_act", int_active, 4'b0000);
    tick(); chk("repend_sig", int_signal, 4'b0001);
    tick(); chk("once_sig", int_signal, 4'b0001);
    rst = 1'b1; irq_in = '0; model_step(); tick(); rst = 1'b0;
    edge_mode = 4'($urandom);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rst) edge_mode = 4'($urandom);
      irq_in = ($urandom_range(0, 1) == 0) ? irq_in : 4'($urandom);
      int_claim = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      int_complete = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      ovf_clear = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      model_step();
      tick();
      chk($sformatf("rnd%0d_sig", c), int_signal, m_vec(0));
      chk($sformatf("rnd%0d_act", c), int_active, m_vec(1));
      chk($sformatf("rnd%0d_ovf", c), edge_ovf, m_vec(2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
